// File: rtl/store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer
//
// Posted-write buffer between a single-cycle core's data-memory port and a
// slower backing data memory. Stores are queued in a small circular FIFO and
// drained in program order over a req/ack handshake. Loads get a zero-wait
// result: the youngest pending store to the same word wins, otherwise the
// backing memory's combinational read data is passed through.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active-low
//   mem_write  core store strobe
//   addr       core byte address (word-aligned, addr[1:0] ignored)
//   wdata      core store data
//   rdata      read data to core (combinational, with store forwarding)
//   stall      store not accepted this cycle (mem_write while full)
//   bus_req    backing write request
//   bus_addr   backing write address (head entry, zero when idle)
//   bus_wdata  backing write data (head entry, zero when idle)
//   bus_ack    backing write complete, only meaningful while bus_req=1
//   mem_raddr  backing read address, always equal to addr
//   mem_rdata  backing read data
//   empty      no buffered entries and no write outstanding
// ----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_write,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          stall,
    output logic          bus_req,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    // Entry storage: word address and data per slot
    logic [AW-3:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    state_e           state_q, state_d;

    logic             full;
    logic             push;
    logic             pop;

    assign full  = (count_q == CW'(DEPTH));
    // A pop in the same cycle does not free the slot early: full is based on
    // the registered count, so stall holds for that cycle.
    assign stall = mem_write & full;
    assign push  = mem_write & ~full;
    assign pop   = (state_q == S_REQ) & bus_ack;

    assign bus_req   = (state_q == S_REQ);
    assign bus_addr  = bus_req ? {addr_q[head_q], 2'b00} : '0;
    assign bus_wdata = bus_req ? data_q[head_q] : '0;
    assign mem_raddr = addr;
    assign empty     = (count_q == '0) & ~bus_req;

    // ------------------------------------------------------------------
    // Next-state: pointers, occupancy, valid bits and drain FSM
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves a variable unassigned, which would infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        state_d = state_q;
        count_d = count_q + CW'(push) - CW'(pop);

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        // Push and pop never target the same slot: push needs count<DEPTH
        // and pop needs count>0, so tail differs from head whenever both fire.
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                // Registered count: bus_req rises one cycle after the first
                // entry lands. bus_ack is ignored here since pop needs S_REQ.
                if (count_q != '0) state_d = S_REQ;
            end
            S_REQ: begin
                // Stay in REQ for back-to-back drain if anything remains
                // after the pop, including an entry pushed this same cycle.
                if (pop && count_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            state_q <= S_IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    // NOTE: the entry payload is deliberately not reset; valid_q and the
    // FSM gate every use of it, so clearing the array would only cost area.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= addr[AW-1:2];
            data_q[tail_q] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read forwarding: walk oldest to youngest so the youngest match wins.
    // The head entry on the bus stays a candidate until it is popped.
    // ------------------------------------------------------------------
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        rdata = mem_rdata;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (addr_q[idx] == addr[AW-1:2])) begin
                rdata = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// ----------------------------------------------------------------------------
// tb_store_buffer
//
// Directed, table-driven bench for store_buffer (DEPTH=4, AW=DW=32). Inputs
// are driven on the falling edge and outputs compared 1 ns later, so every
// vector describes one clock cycle: its inputs and the outputs expected
// before the following rising edge. Reset behaviour is exercised by
// hand-written sequences before and after the table.
// ----------------------------------------------------------------------------
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        empty;

    int n_vec  = 0;
    int n_miss = 0;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mw;
        logic [31:0] a;
        logic [31:0] wd;
        logic        ack;
        logic [31:0] mrd;
        logic [31:0] e_rd;
        logic        e_st;
        logic        e_rq;
        logic [31:0] e_ba;
        logic [31:0] e_bw;
        logic        e_em;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic mw, input logic [31:0] a,
                                input logic [31:0] wd, input logic ack,
                                input logic [31:0] mrd, input logic [31:0] e_rd,
                                input logic e_st, input logic e_rq,
                                input logic [31:0] e_ba, input logic [31:0] e_bw,
                                input logic e_em);
        vec_t v;
        v.mw = mw;   v.a = a;       v.wd = wd;     v.ack = ack;  v.mrd = mrd;
        v.e_rd = e_rd; v.e_st = e_st; v.e_rq = e_rq;
        v.e_ba = e_ba; v.e_bw = e_bw; v.e_em = e_em;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive on falling edge, compare 1 ns later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        mem_write = v.mw;
        addr      = v.a;
        wdata     = v.wd;
        bus_ack   = v.ack;
        mem_rdata = v.mrd;
        #1;
        n_vec++;
        check($sformatf("v%0d.rdata", n_vec),   rdata,          v.e_rd);
        check($sformatf("v%0d.stall", n_vec),   32'(stall),     32'(v.e_st));
        check($sformatf("v%0d.bus_req", n_vec), 32'(bus_req),   32'(v.e_rq));
        check($sformatf("v%0d.empty", n_vec),   32'(empty),     32'(v.e_em));
        check($sformatf("v%0d.mem_raddr", n_vec), mem_raddr,    v.a);
        if (v.e_rq) begin
            check($sformatf("v%0d.bus_addr", n_vec),  bus_addr,  v.e_ba);
            check($sformatf("v%0d.bus_wdata", n_vec), bus_wdata, v.e_bw);
        end
    endtask

    // Same as apply, built from arguments for the hand-written sequences.
    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                        input logic ack, input logic [31:0] mrd, input logic [31:0] e_rd,
                        input logic e_st, input logic e_rq, input logic [31:0] e_ba,
                        input logic [31:0] e_bw, input logic e_em);
        vec_t v;
        v.mw = mw;   v.a = a;       v.wd = wd;     v.ack = ack;  v.mrd = mrd;
        v.e_rd = e_rd; v.e_st = e_st; v.e_rq = e_rq;
        v.e_ba = e_ba; v.e_bw = e_bw; v.e_em = e_em;
        apply(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- table: single store, forwarding, full, wrap -----
        //   mw  addr       wdata          ack mem_rdata  exp_rdata      st rq bus_addr  bus_wdata      empty
        // single store, ack tied high; ack in IDLE is ignored
        add(1, 32'h100, 32'h1111_1111, 1, 32'h0,  32'h0,         0, 0, 32'h0,   32'h0,         1);
        add(0, 32'h100, 32'h0,         1, 32'h0,  32'h1111_1111, 0, 0, 32'h0,   32'h0,         0);
        add(0, 32'h100, 32'h0,         1, 32'h0,  32'h1111_1111, 0, 1, 32'h100, 32'h1111_1111, 0);
        add(0, 32'h100, 32'h0,         0, 32'h55, 32'h55,        0, 0, 32'h0,   32'h0,         1);
        // forwarding: youngest wins, no self-forward, neighbour word misses
        add(1, 32'h200, 32'hA,   0, 32'h0,    32'h0,    0, 0, 32'h0,   32'h0, 1);
        add(1, 32'h200, 32'hB,   0, 32'h0,    32'hA,    0, 0, 32'h0,   32'h0, 0);
        add(0, 32'h200, 32'h0,   0, 32'h0,    32'hB,    0, 1, 32'h200, 32'hA, 0);
        add(0, 32'h204, 32'h0,   0, 32'h1234, 32'h1234, 0, 1, 32'h200, 32'hA, 0);
        add(0, 32'h200, 32'h0,   1, 32'h0,    32'hB,    0, 1, 32'h200, 32'hA, 0);
        add(0, 32'h200, 32'h0,   1, 32'h0,    32'hB,    0, 1, 32'h200, 32'hB, 0);
        add(0, 32'h200, 32'h0,   0, 32'h9,    32'h9,    0, 0, 32'h0,   32'h0, 1);
        // full and stall; pop in the same cycle keeps stall high
        add(1, 32'h0,  32'hD0, 0, 32'h77, 32'h77, 0, 0, 32'h0,  32'h0,  1);
        add(1, 32'h4,  32'hD1, 0, 32'h77, 32'h77, 0, 0, 32'h0,  32'h0,  0);
        add(1, 32'h8,  32'hD2, 0, 32'h77, 32'h77, 0, 1, 32'h0,  32'hD0, 0);
        add(1, 32'hC,  32'hD3, 0, 32'h77, 32'h77, 0, 1, 32'h0,  32'hD0, 0);
        add(1, 32'h10, 32'hD4, 0, 32'h77, 32'h77, 1, 1, 32'h0,  32'hD0, 0);
        add(1, 32'h10, 32'hD4, 1, 32'h77, 32'h77, 1, 1, 32'h0,  32'hD0, 0);
        add(1, 32'h10, 32'hD4, 0, 32'h77, 32'h77, 0, 1, 32'h4,  32'hD1, 0);
        add(0, 32'h10, 32'h0,  1, 32'h77, 32'hD4, 0, 1, 32'h4,  32'hD1, 0);
        add(0, 32'h0,  32'h0,  1, 32'h77, 32'h77, 0, 1, 32'h8,  32'hD2, 0);
        add(0, 32'h0,  32'h0,  1, 32'h77, 32'h77, 0, 1, 32'hC,  32'hD3, 0);
        add(0, 32'h0,  32'h0,  1, 32'h77, 32'h77, 0, 1, 32'h10, 32'hD4, 0);
        add(0, 32'h0,  32'h0,  0, 32'h77, 32'h77, 0, 0, 32'h0,  32'h0,  1);
        // back-to-back drain with pointer wrap, ack held high
        add(1, 32'h300, 32'hB000_0000, 1, 32'h0, 32'h0,         0, 0, 32'h0,   32'h0,         1);
        add(1, 32'h304, 32'hB000_0001, 1, 32'h0, 32'h0,         0, 0, 32'h0,   32'h0,         0);
        add(1, 32'h308, 32'hB000_0002, 1, 32'h0, 32'h0,         0, 1, 32'h300, 32'hB000_0000, 0);
        add(1, 32'h30C, 32'hB000_0003, 1, 32'h0, 32'h0,         0, 1, 32'h304, 32'hB000_0001, 0);
        add(1, 32'h310, 32'hB000_0004, 1, 32'h0, 32'h0,         0, 1, 32'h308, 32'hB000_0002, 0);
        add(1, 32'h314, 32'hB000_0005, 1, 32'h0, 32'h0,         0, 1, 32'h30C, 32'hB000_0003, 0);
        add(0, 32'h314, 32'h0,         1, 32'h0, 32'hB000_0005, 0, 1, 32'h310, 32'hB000_0004, 0);
        add(0, 32'h317, 32'h0,         1, 32'h0, 32'hB000_0005, 0, 1, 32'h314, 32'hB000_0005, 0);
        add(0, 32'h314, 32'h0,         0, 32'h3, 32'h3,         0, 0, 32'h0,   32'h0,         1);

        // ---------------- reset then idle ---------------------------------
        reset     = 1'b0;
        mem_write = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        bus_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        check("reset.bus_req", 32'(bus_req), 32'h0);
        check("reset.empty",   32'(empty),   32'h1);
        check("reset.stall",   32'(stall),   32'h0);
        check("reset.bus_addr", bus_addr,    32'h0);
        reset = 1'b1;
        step(0, 32'h0, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 1);

        // ---------------- table ----------------------------------------------
        foreach (vecs[i]) apply(vecs[i]);

        // ---------------- reset mid-operation ------------------------------
        step(1, 32'h400, 32'hE0, 0, 32'h0, 32'h0,  0, 0, 32'h0,   32'h0,  1);
        step(1, 32'h404, 32'hE1, 0, 32'h0, 32'h0,  0, 0, 32'h0,   32'h0,  0);
        step(1, 32'h408, 32'hE2, 0, 32'h0, 32'h0,  0, 1, 32'h400, 32'hE0, 0);
        step(0, 32'h408, 32'h0,  0, 32'h0, 32'hE2, 0, 1, 32'h400, 32'hE0, 0);
        // Mid-cycle, well away from any rising edge
        #2;
        mem_rdata = 32'h66;
        reset     = 1'b0;
        #1;
        n_vec++;
        check("midrst.bus_req",   32'(bus_req), 32'h0);
        check("midrst.empty",     32'(empty),   32'h1);
        check("midrst.stall",     32'(stall),   32'h0);
        check("midrst.rdata",     rdata,        32'h66);
        check("midrst.bus_wdata", bus_wdata,    32'h0);
        bus_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        // Discarded stores never reach the bus and are no longer forwarded
        for (int i = 0; i < 4; i++) begin
            step(0, 32'h408, 32'h0, 1, 32'h66, 32'h66, 0, 0, 32'h0, 32'h0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer sitting directly downstream of the single-cycle core's data-memory port (MemWrite, ALUResult, WriteData, ReadData).
- Accepts one word store per cycle into a small FIFO and returns a zero-wait-state read result to the core, forwarding from pending stores.
- Drains stores to a slower backing data memory over a req/ack handshake.
- Asserts stall toward the core when a store arrives while the buffer is full.

Parameters:
DEPTH, 4, number of buffered stores; power of two, minimum 2
AW, 32, address width in bits
DW, 32, data width in bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low (asserted when 0)
mem_write  input  1  core store strobe (MemWrite)
addr  input  AW  core byte address (ALUResult); word-aligned
wdata  input  DW  core store data (WriteData)
rdata  output  DW  read data to core (ReadData), combinational
stall  output  1  store not accepted this cycle; core must hold PC and all signals
bus_req  output  1  backing write request
bus_addr  output  AW  backing write address
bus_wdata  output  DW  backing write data
bus_ack  input  1  backing write complete; valid only while bus_req=1
mem_raddr  output  AW  backing read address; always equals addr
mem_rdata  input  DW  backing read data, combinational from mem_raddr
empty  output  1  buffer holds no entries and no write is outstanding

Behaviour:
- Reset (reset=0, asynchronous): count=0, head=tail=0, all entry valid bits cleared, FSM=IDLE. Outputs go immediately to bus_req=0, bus_addr=0, bus_wdata=0, stall=0, empty=1. Pending stores are discarded, including a write in flight; a bus_ack arriving during or after reset is ignored.
- Storage: circular FIFO of DEPTH entries {addr[AW-1:2], data}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH. full=(count==DEPTH).
- Enqueue: on a clk edge where mem_write=1 and full=0, write the entry at tail, then tail+1.
  - stall = mem_write & full, combinational.
  - A pop in the same cycle does not unblock a full buffer; stall is still 1 that cycle.
- Drain FSM:
  - IDLE: if count>0, go to REQ. bus_req is registered and asserts one cycle after the first entry lands.
  - REQ: bus_req=1. bus_addr = {head.addr,2'b00} and bus_wdata = head.data, held stable until ack.
    - On an edge with bus_ack=1: pop the head (head+1, count-1).
    - If the post-pop count>0, stay in REQ and present the next entry in the next cycle (back-to-back; bus_req stays 1).
    - Otherwise go to IDLE with bus_req=0.
  - bus_ack while in IDLE is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Read forwarding:
  - rdata = data of the youngest valid entry whose addr[AW-1:2] matches addr[AW-1:2]; otherwise rdata = mem_rdata.
  - The head entry currently on the bus is still a forwarding candidate until popped.
  - Forwarding is evaluated every cycle regardless of mem_write. A store in the current cycle is not forwarded to itself.
- Multiple stores to the same word are not coalesced; each drains in program order.
- empty = (count==0) & ~bus_req.
- Addresses are not range-checked; addr[1:0] is ignored.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, no stimulus -> bus_req=0, empty=1, stall=0. With mem_rdata=32'hDEAD_BEEF, rdata=32'hDEAD_BEEF.
- Single store and drain: store addr=0x100, wdata=0x11111111, bus_ack tied 1 -> bus_req=1 next cycle with bus_addr=0x100, bus_wdata=0x11111111. Pops after one cycle, then empty=1.
- Forwarding, youngest wins: with bus_ack=0, store 0x200←0xA and then 0x200←0xB. Read addr=0x200 with mem_rdata=0 -> rdata=0xB. Read addr=0x204 -> rdata=mem_rdata.
- Full and stall: bus_ack=0, 4 stores to 0x0/0x4/0x8/0xC, then a 5th store to 0x10 -> stall=1 and count stays 4. Pulse bus_ack for 1 cycle -> 0x0 popped. The held 5th store is accepted on the next edge and stall drops. Drain order is 0x4, 0x8, 0xC, 0x10.
- Back-to-back drain with wrap: push 6 stores with bus_ack=1 continuously while pushing 1 per cycle -> bus_req stays high without gaps. Pointers wrap past 3. Bus sequence matches push order and data exactly.
- Reset mid-operation: 3 entries pending and bus_req=1 -> assert reset asynchronously mid-cycle. bus_req falls without waiting for clk, empty=1, and no further bus writes occur after release.
